// File: rtl/mem_wb_writeback_pkg.sv
// Shared RV32I pipeline definitions: load encodings, register-address width
// and the MEM/WB stage-register layout.
package rv32i_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_DEPTH  = 32;
  localparam int REG_ADDR_W = $clog2(REG_DEPTH);

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [2:0]            funct3;
    logic [1:0]            addr_lsb;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0]     alu_result;
  } mem_wb_t;

  // Sign- or zero-extend a byte to a full word.
  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    ext_byte = {{(DATA_W-8){sgn & b[7]}}, b};
  endfunction

  // Sign- or zero-extend a halfword to a full word.
  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
    ext_half = {{(DATA_W-16){sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_wb_writeback_if.sv
// MEM-to-WB bus: stage controls and MEM results in, register-file write port out.
interface mem_wb_writeback_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_DEPTH  = 32
);
  localparam int AW = $clog2(REG_DEPTH);

  logic                  stall_i;
  logic                  flush_i;
  logic                  valid_i;
  logic                  reg_write_i;
  logic                  mem_to_reg_i;
  logic [2:0]            funct3_i;
  logic [1:0]            addr_lsb_i;
  logic [AW-1:0]         rd_addr_i;
  logic [DATA_WIDTH-1:0] alu_result_i;
  logic [DATA_WIDTH-1:0] sram_rdata_i;
  logic [AW-1:0]         rd_addr_o;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  reg_write_o;
  logic                  wb_valid_o;
  logic                  load_err_o;

  modport master (
    output stall_i, flush_i, valid_i, reg_write_i, mem_to_reg_i, funct3_i,
           addr_lsb_i, rd_addr_i, alu_result_i, sram_rdata_i,
    input  rd_addr_o, rd_data_o, reg_write_o, wb_valid_o, load_err_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, reg_write_i, mem_to_reg_i, funct3_i,
           addr_lsb_i, rd_addr_i, alu_result_i, sram_rdata_i,
    output rd_addr_o, rd_data_o, reg_write_o, wb_valid_o, load_err_o
  );
endinterface

// File: rtl/mem_wb_writeback_load_align.sv
// Load data aligner: picks the addressed byte/half from the SRAM word,
// extends it per the load type and flags misaligned or illegal loads.
module load_align
  import rv32i_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lsb,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [DATA_W-1:0] raw_s;
  logic              err_s;

  // Lane select, extension and error decode for the current load.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    raw_s  = {DATA_W{1'b0}};
    err_s  = 1'b0;
    case (addr_lsb)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lsb[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (funct3)
      LB:  raw_s = ext_byte(byte_s, 1'b1);
      LBU: raw_s = ext_byte(byte_s, 1'b0);
      LH: begin
        raw_s = ext_half(half_s, 1'b1);
        err_s = addr_lsb[0];
      end
      LHU: begin
        raw_s = ext_half(half_s, 1'b0);
        err_s = addr_lsb[0];
      end
      LW: begin
        raw_s = word;
        err_s = (addr_lsb != 2'b00);
      end
      default: begin
        raw_s = {DATA_W{1'b0}};
        err_s = 1'b1;
      end
    endcase
  end

  // A faulting load never exposes data.
  assign data = err_s ? {DATA_W{1'b0}} : raw_s;
  assign err  = err_s;

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB stage register and register-file write-port driver. Load data from
// the SRAM is only valid in the first WB cycle, so it is captured into a hold
// register when the stage stalls.
module mem_wb_writeback
  import rv32i_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int REG_DEPTH  = 32
)(
  input logic               clk_i,
  input logic               rst_ni,
  mem_wb_writeback_if.slave bus
);

  localparam int AW = $clog2(REG_DEPTH);

  mem_wb_t               stage_r;
  logic                  held_r;
  logic [DATA_WIDTH-1:0] hold_q_r;
  logic [DATA_WIDTH-1:0] src_word_s;
  logic [DATA_WIDTH-1:0] aligned_s;
  logic                  align_err_s;
  logic                  load_err_s;
  logic                  advance_s;

  assign advance_s = !bus.stall_i || bus.flush_i;

  // Stage register: flush beats stall, stall holds, otherwise capture MEM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_r <= '0;
    end else if (bus.flush_i) begin
      stage_r.valid <= 1'b0;
    end else if (bus.stall_i) begin
      stage_r <= stage_r;
    end else begin
      stage_r.valid      <= bus.valid_i;
      stage_r.reg_write  <= bus.reg_write_i;
      stage_r.mem_to_reg <= bus.mem_to_reg_i;
      stage_r.funct3     <= bus.funct3_i;
      stage_r.addr_lsb   <= bus.addr_lsb_i;
      stage_r.rd_addr    <= bus.rd_addr_i;
      stage_r.alu_result <= bus.alu_result_i;
    end
  end

  // Capture the SRAM word on the first stalled cycle of a load; drop it when the stage moves.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_r   <= 1'b0;
      hold_q_r <= {DATA_WIDTH{1'b0}};
    end else if (advance_s) begin
      held_r   <= 1'b0;
    end else if (stage_r.valid && stage_r.mem_to_reg && !held_r) begin
      held_r   <= 1'b1;
      hold_q_r <= bus.sram_rdata_i;
    end else begin
      held_r   <= held_r;
    end
  end

  assign src_word_s = held_r ? hold_q_r : bus.sram_rdata_i;

  load_align u_load_align (
    .word     (src_word_s),
    .funct3   (stage_r.funct3),
    .addr_lsb (stage_r.addr_lsb),
    .data     (aligned_s),
    .err      (align_err_s)
  );

  assign load_err_s = stage_r.valid && stage_r.mem_to_reg && align_err_s;

  // Write-data select: bubble, load result or ALU/link result.
  always_comb begin
    bus.rd_data_o = {DATA_WIDTH{1'b0}};
    if (!stage_r.valid) begin
      bus.rd_data_o = {DATA_WIDTH{1'b0}};
    end else if (stage_r.mem_to_reg) begin
      bus.rd_data_o = aligned_s;
    end else begin
      bus.rd_data_o = stage_r.alu_result;
    end
  end

  assign bus.reg_write_o = stage_r.valid && stage_r.reg_write &&
                           (stage_r.rd_addr != {AW{1'b0}}) && !load_err_s;
  assign bus.rd_addr_o   = stage_r.rd_addr;
  assign bus.wb_valid_o  = stage_r.valid;
  assign bus.load_err_o  = load_err_s;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed self-checking bench for mem_wb_writeback.
module tb_mem_wb_writeback;

  logic clk_i;
  logic rst_ni;
  int   pass_cnt;
  int   total_cnt;

  mem_wb_writeback_if #(.DATA_WIDTH(32), .REG_DEPTH(32)) bus ();

  mem_wb_writeback #(.DATA_WIDTH(32), .REG_DEPTH(32)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Present one MEM-stage instruction.
  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] f3,
                       input logic [1:0] lsb, input logic [4:0] rd, input logic [31:0] alu);
    bus.valid_i      = v;
    bus.reg_write_i  = rw;
    bus.mem_to_reg_i = m2r;
    bus.funct3_i     = f3;
    bus.addr_lsb_i   = lsb;
    bus.rd_addr_i    = rd;
    bus.alu_result_i = alu;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 5'd0, 32'h0);
  endtask

  // Capture the driven instruction at the next edge and place sram word in its WB cycle.
  task automatic capture(input logic [31:0] sram);
    @(posedge clk_i);
    #1;
    bubble();
    bus.sram_rdata_i = sram;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.sram_rdata_i = 32'hFFFF_FFFF;
    bubble();
    #12;
    total_cnt++; if (bus.rd_data_o !== 32'h0) $display("FAIL reset_rd_data got %h want %h", bus.rd_data_o, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.reg_write_o !== 1'b0) $display("FAIL reset_reg_write got %b want 0", bus.reg_write_o); else pass_cnt++;
    total_cnt++; if (bus.wb_valid_o !== 1'b0) $display("FAIL reset_wb_valid got %b want 0", bus.wb_valid_o); else pass_cnt++;
    total_cnt++; if (bus.rd_addr_o !== 5'd0) $display("FAIL reset_rd_addr got %0d want 0", bus.rd_addr_o); else pass_cnt++;
    total_cnt++; if (bus.load_err_o !== 1'b0) $display("FAIL reset_load_err got %b want 0", bus.load_err_o); else pass_cnt++;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_lb();
    @(negedge clk_i);
    drive(1'b1, 1'b1, 1'b1, 3'b000, 2'd3, 5'd5, 32'h0);
    capture(32'h80FF_1234);
    total_cnt++; if (bus.rd_data_o !== 32'hFFFF_FF80) $display("FAIL lb_data got %h want %h", bus.rd_data_o, 32'hFFFF_FF80); else pass_cnt++;
    total_cnt++; if (bus.reg_write_o !== 1'b1) $display("FAIL lb_reg_write got %b want 1", bus.reg_write_o); else pass_cnt++;
    total_cnt++; if (bus.rd_addr_o !== 5'd5) $display("FAIL lb_rd_addr got %0d want 5", bus.rd_addr_o); else pass_cnt++;
    total_cnt++; if (bus.load_err_o !== 1'b0) $display("FAIL lb_load_err got %b want 0", bus.load_err_o); else pass_cnt++;
    // LBU of the same byte lane, then LH sign-extended from upper half.
    @(negedge clk_i);
    drive(1'b1, 1'b1, 1'b1, 3'b100, 2'd3, 5'd6, 32'h0);
    capture(32'h80FF_1234);
    total_cnt++; if (bus.rd_data_o !== 32'h0000_0080) $display("FAIL lbu_data got %h want %h", bus.rd_data_o, 32'h0000_0080); else pass_cnt++;
    @(negedge clk_i);
    drive(1'b1, 1'b1, 1'b1, 3'b001, 2'd2, 5'd6, 32'h0);
    capture(32'h80FF_1234);
    total_cnt++; if (bus.rd_data_o !== 32'hFFFF_80FF) $display("FAIL lh_data got %h want %h", bus.rd_data_o, 32'hFFFF_80FF); else pass_cnt++;
  endtask

  task automatic test_lhu();
    @(negedge clk_i);
    drive(1'b1, 1'b1, 1'b1, 3'b101, 2'd2, 5'd9, 32'h0);
    capture(32'hBEEF_0001);
    total_cnt++; if (bus.rd_data_o !== 32'h0000_BEEF) $display("FAIL lhu_data got %h want %h", bus.rd_data_o, 32'h0000_BEEF); else pass_cnt++;
    total_cnt++; if (bus.reg_write_o !== 1'b1) $display("FAIL lhu_reg_write got %b want 1", bus.reg_write_o); else pass_cnt++;
    @(negedge clk_i);
    drive(1'b1, 1'b1, 1'b1, 3'b101, 2'd1, 5'd9, 32'h0);
    capture(32'hBEEF_0001);
    total_cnt++; if (bus.load_err_o !== 1'b1) $display("FAIL lhu_mis_err got %b want 1", bus.load_err_o); else pass_cnt++;
    total_cnt++; if (bus.reg_write_o !== 1'b0) $display("FAIL lhu_mis_reg_write got %b want 0", bus.reg_write_o); else pass_cnt++;
    total_cnt++; if (bus.rd_data_o !== 32'h0) $display("FAIL lhu_mis_data got %h want 0", bus.rd_data_o); else pass_cnt++;
    // Illegal funct3 011 and misaligned LW.
    @(negedge clk_i);
    drive(1'b1, 1'b1, 1'b1, 3'b011, 2'd0, 5'd9, 32'h0);
    capture(32'h1234_5678);
    total_cnt++; if (bus.load_err_o !== 1'b1) $display("FAIL illegal_f3_err got %b want 1", bus.load_err_o); else pass_cnt++;
    @(negedge clk_i);
    drive(1'b1, 1'b1, 1'b1, 3'b010, 2'd2, 5'd9, 32'h0);
    capture(32'h1234_5678);
    total_cnt++; if (bus.load_err_o !== 1'b1) $display("FAIL lw_mis_err got %b want 1", bus.load_err_o); else pass_cnt++;
  endtask

  task automatic test_lw_stall();
    @(negedge clk_i);
    drive(1'b1, 1'b1, 1'b1, 3'b010, 2'd0, 5'd10, 32'h0);
    @(posedge clk_i);
    #1;
    bubble();
    bus.stall_i = 1'b1;
    bus.sram_rdata_i = 32'hDEAD_BEEF;
    #1;
    total_cnt++; if (bus.rd_data_o !== 32'hDEAD_BEEF) $display("FAIL lw_stall_c1 got %h want %h", bus.rd_data_o, 32'hDEAD_BEEF); else pass_cnt++;
    for (int i = 2; i <= 4; i++) begin
      @(posedge clk_i);
      #1;
      bus.sram_rdata_i = 32'h0;
      bus.stall_i = (i < 4);
      #1;
      total_cnt++; if (bus.rd_data_o !== 32'hDEAD_BEEF) $display("FAIL lw_stall_c%0d got %h want %h", i, bus.rd_data_o, 32'hDEAD_BEEF); else pass_cnt++;
      total_cnt++; if (bus.reg_write_o !== 1'b1) $display("FAIL lw_stall_we_c%0d got %b want 1", i, bus.reg_write_o); else pass_cnt++;
    end
    @(posedge clk_i);
    #2;
    total_cnt++; if (bus.wb_valid_o !== 1'b0) $display("FAIL lw_stall_drain got %b want 0", bus.wb_valid_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    drive(1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 5'd0, 32'h0000_1234);
    @(posedge clk_i);
    #1;
    drive(1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 5'd7, 32'h0000_1234);
    #1;
    total_cnt++; if (bus.reg_write_o !== 1'b0) $display("FAIL alu_rd0_we got %b want 0", bus.reg_write_o); else pass_cnt++;
    total_cnt++; if (bus.rd_data_o !== 32'h0000_1234) $display("FAIL alu_rd0_data got %h want %h", bus.rd_data_o, 32'h0000_1234); else pass_cnt++;
    @(posedge clk_i);
    #1;
    bubble();
    bus.stall_i = 1'b1;
    bus.sram_rdata_i = 32'hAAAA_5555;
    #1;
    total_cnt++; if (bus.reg_write_o !== 1'b1) $display("FAIL alu_rd7_we got %b want 1", bus.reg_write_o); else pass_cnt++;
    total_cnt++; if (bus.rd_addr_o !== 5'd7) $display("FAIL alu_rd7_addr got %0d want 7", bus.rd_addr_o); else pass_cnt++;
    // Non-load held through a stall keeps its ALU result.
    @(posedge clk_i);
    #1;
    bus.sram_rdata_i = 32'h5555_AAAA;
    bus.stall_i = 1'b0;
    #1;
    total_cnt++; if (bus.rd_data_o !== 32'h0000_1234) $display("FAIL alu_stall_data got %h want %h", bus.rd_data_o, 32'h0000_1234); else pass_cnt++;
  endtask

  task automatic test_flush();
    @(negedge clk_i);
    drive(1'b1, 1'b1, 1'b1, 3'b010, 2'd0, 5'd12, 32'h0);
    @(posedge clk_i);
    #1;
    bubble();
    bus.sram_rdata_i = 32'hCAFE_F00D;
    bus.stall_i = 1'b1;
    bus.flush_i = 1'b1;
    #1;
    total_cnt++; if (bus.wb_valid_o !== 1'b1) $display("FAIL flush_pre_valid got %b want 1", bus.wb_valid_o); else pass_cnt++;
    @(posedge clk_i);
    #1;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    total_cnt++; if (bus.wb_valid_o !== 1'b0) $display("FAIL flush_valid got %b want 0", bus.wb_valid_o); else pass_cnt++;
    total_cnt++; if (bus.reg_write_o !== 1'b0) $display("FAIL flush_we got %b want 0", bus.reg_write_o); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    // Load stalled long enough to set the hold register, then reset mid-cycle.
    @(negedge clk_i);
    drive(1'b1, 1'b1, 1'b1, 3'b010, 2'd0, 5'd13, 32'h0);
    @(posedge clk_i);
    #1;
    bubble();
    bus.stall_i = 1'b1;
    bus.sram_rdata_i = 32'h0BAD_0BAD;
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    total_cnt++; if (bus.wb_valid_o !== 1'b0) $display("FAIL areset_valid got %b want 0", bus.wb_valid_o); else pass_cnt++;
    total_cnt++; if (bus.rd_data_o !== 32'h0) $display("FAIL areset_data got %h want 0", bus.rd_data_o); else pass_cnt++;
    total_cnt++; if (bus.rd_addr_o !== 5'd0) $display("FAIL areset_addr got %0d want 0", bus.rd_addr_o); else pass_cnt++;
    bus.stall_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    // First load after reset must read the live SRAM word, not a stale hold.
    drive(1'b1, 1'b1, 1'b1, 3'b010, 2'd0, 5'd14, 32'h0);
    capture(32'h1122_3344);
    total_cnt++; if (bus.rd_data_o !== 32'h1122_3344) $display("FAIL post_reset_load got %h want %h", bus.rd_data_o, 32'h1122_3344); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_lb();
    test_lhu();
    test_lw_stall();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_wb_writeback.md
# mem_wb_writeback

MEM/WB pipeline stage and register-file write-port driver for the RV32I pipeline. Captures the MEM-stage result, aligns and sign/zero-extends load data that the data SRAM returns one cycle after the address, and presents `rd_addr_o`/`rd_data_o`/`reg_write_o` to the register file. Holds load data across stalls, because the SRAM output does not persist.

## Interface
- `DATA_WIDTH`, 32, datapath width.
- `REG_DEPTH`, 32, number of architectural registers; address width is `$clog2(REG_DEPTH)`.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `stall_i` in 1: hold the stage register.
- `flush_i` in 1: load a bubble into the stage.
- `valid_i` in 1: MEM-stage instruction valid.
- `reg_write_i` in 1: instruction writes `rd`.
- `mem_to_reg_i` in 1: instruction is a load.
- `funct3_i` in 3: load type.
- `addr_lsb_i` in 2: byte offset of the load address.
- `rd_addr_i` in `$clog2(REG_DEPTH)`: destination register.
- `alu_result_i` in `DATA_WIDTH`: non-load result, including the link value.
- `sram_rdata_i` in `DATA_WIDTH`: raw SRAM word; valid in the first WB cycle of a load.
- `rd_addr_o` out `$clog2(REG_DEPTH)`: register-file write address.
- `rd_data_o` out `DATA_WIDTH`: register-file write data.
- `reg_write_o` out 1: register-file write enable.
- `wb_valid_o` out 1: stage holds a valid instruction.
- `load_err_o` out 1: current WB load is misaligned or has an illegal `funct3`.

## Operation
- **Stage register.** Fields: valid, reg_write, mem_to_reg, funct3, addr_lsb, rd_addr, alu_result. Updated on each clock edge, by priority:
  - `flush_i`: valid←0; other fields don't-care. Flush wins over stall.
  - else `stall_i`: hold all fields.
  - else: load all fields from the inputs.
- **Hold logic.** A `held` flag and a `hold_q` data register.
  - Set: `held`←1 and `hold_q`←`sram_rdata_i` when valid & mem_to_reg & `stall_i` & !`held`.
  - Clear: `held`←0 whenever the stage advances (`!stall_i` or `flush_i`).
- **Load source word** = `held ? hold_q : sram_rdata_i`.
- **Load alignment by `funct3`:**
  - LB (000): byte at `addr_lsb`, sign-extended.
  - LBU (100): byte at `addr_lsb`, zero-extended.
  - LH (001): half at `addr_lsb[1]`, sign-extended.
  - LHU (101): half at `addr_lsb[1]`, zero-extended.
  - LW (010): full word.
- **Load error.**
  - Misaligned: LH/LHU with `addr_lsb[0]`=1, or LW with `addr_lsb`≠0.
  - Illegal `funct3`: 011, 110, 111.
  - On error: `load_err_o`=1 while the instruction sits in WB, `reg_write_o`=0, `rd_data_o`=0.
- **Outputs:**
  - `rd_data_o` = 0 if !valid; else aligned load data if mem_to_reg; else alu_result.
  - `reg_write_o` = valid & reg_write & (rd_addr≠0) & !`load_err_o`.
  - `rd_addr_o` = stage rd_addr.
  - `wb_valid_o` = valid.
- Repeated write assertion during a stall is allowed. The write is idempotent because the data is held.

## Timing
- Reset (`rst_ni`=0, asynchronous): all stage fields, `held` and `hold_q` go to 0. Consequently every output is 0.
- Latency: MEM inputs are captured at edge N; WB outputs are valid during cycle N+1. All outputs are combinational from stage state plus `sram_rdata_i`/`hold_q`; there is no added latency.
- SRAM contract: `sram_rdata_i` is guaranteed only in the first WB cycle of a load. After that cycle, `hold_q` supplies the data.
- Stall of k cycles on a load: `rd_data_o` is constant for all k+1 cycles, even if `sram_rdata_i` changes after the first cycle.
- Simultaneous `stall_i` and `flush_i`: the flush takes effect and `held` clears.
- Reset asserted mid-stall: state clears immediately. After release, the first captured instruction starts with `held`=0.
- Non-load under stall: `held` never sets, and `rd_data_o` = alu_result.

## Structure
- Shared package (`rv32i_pkg`):
  - `load_funct3_e` enum with LB/LH/LW/LBU/LHU encodings.
  - `REG_ADDR_W` constant.
  - Packed struct `mem_wb_t` holding the stage fields.
- One sub-module, `load_align`: purely combinational. Takes word, `funct3` and `addr_lsb`; returns aligned data and the error flag.

## Test plan
- LB, `addr_lsb`=3, SRAM word 0x80FF_1234, rd=5 → `rd_data_o`=0xFFFF_FF80, `reg_write_o`=1, `rd_addr_o`=5, one cycle after capture.
- LHU, `addr_lsb`=2, word 0xBEEF_0001 → 0x0000_BEEF. Same load with `addr_lsb`=1 → `load_err_o`=1, `reg_write_o`=0.
- LW of 0xDEAD_BEEF stalled 3 cycles, with `sram_rdata_i` changed to 0x0 after the first WB cycle → `rd_data_o`=0xDEAD_BEEF in all 4 cycles.
- ALU op with rd=0, `alu_result_i`=0x1234 → `reg_write_o`=0, `rd_data_o`=0x1234. The same op with rd=7 → `reg_write_o`=1.
- Reset and flush:
  - `flush_i` and `stall_i` together, with a valid LW in the stage → next cycle `wb_valid_o`=0 and `reg_write_o`=0.
  - Asynchronous reset pulsed mid-cycle → all outputs 0 immediately, without waiting for a clock edge.
